// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Sequencing controller for a 5-stage MIPS pipeline. It detects the hazards
// that the ID-stage forwarding paths cannot cover:
//   - load-use (LU)
//   - branch-on-ALU-result in EX (BA)
//   - branch-on-load-result in MEM (BL)
// It also runs the run/drain/halt/step FSM that is driven by the HALT
// instruction and by the debug unit.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rs_id, i_rt_id    source registers of the ID instruction, with use flags
//   i_branch_id         ID instruction resolves a branch/jr in ID
//   i_halt_id           ID instruction is HALT
//   i_rd_ex, i_regWrite_ex, i_memRead_ex   destination info of ID/EX
//   i_rd_ex_m, i_memRead_ex_m              destination info of EX/MEM
//   i_dbg_halt_req      debug halt request (level)
//   i_dbg_step          one-cycle pulse, run one cycle while halted
//   i_dbg_run           one-cycle pulse, resume from a debug halt
//   o_pc_write          PC update enable
//   o_if_id_write       IF/ID update enable
//   o_id_ex_flush       load a bubble into ID/EX
//   o_pipe_en           enable for the ID/EX, EX/MEM and MEM/WB registers
//   o_halted            FSM is in HALTED
//   o_program_end       halt came from a HALT instruction (sticky until reset)
//   o_stall_count       saturating count of hazard-stall cycles
module hazard_stall_controller #(
    parameter int NB_ADDR      = 5,
    parameter int NB_CNT       = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_ADDR-1:0] i_rs_id,
    input  logic [NB_ADDR-1:0] i_rt_id,
    input  logic               i_use_rs_id,
    input  logic               i_use_rt_id,
    input  logic               i_branch_id,
    input  logic               i_halt_id,
    input  logic [NB_ADDR-1:0] i_rd_ex,
    input  logic               i_regWrite_ex,
    input  logic               i_memRead_ex,
    input  logic [NB_ADDR-1:0] i_rd_ex_m,
    input  logic               i_memRead_ex_m,
    input  logic               i_dbg_halt_req,
    input  logic               i_dbg_step,
    input  logic               i_dbg_run,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_id_ex_flush,
    output logic               o_pipe_en,
    output logic               o_halted,
    output logic               o_program_end,
    output logic [NB_CNT-1:0]  o_stall_count
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   drain_cnt, drain_cnt_next;
    logic            program_end, program_end_next;
    logic [NB_CNT-1:0] stall_cnt;
    logic            stall_inc;

    logic match_ex, match_ex_m;
    logic hz_lu, hz_ba, hz_bl, hz;

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        if (&v)
            return v;
        else
            return v + NB_CNT'(1);
    endfunction

    // Register 0 is hard-wired to zero, so a zero destination never conflicts.
    assign match_ex   = (|i_rd_ex) &&
                        ((i_use_rs_id && (i_rs_id == i_rd_ex)) ||
                         (i_use_rt_id && (i_rt_id == i_rd_ex)));
    assign match_ex_m = (|i_rd_ex_m) &&
                        ((i_use_rs_id && (i_rs_id == i_rd_ex_m)) ||
                         (i_use_rt_id && (i_rt_id == i_rd_ex_m)));

    assign hz_lu = i_memRead_ex && match_ex;
    assign hz_ba = i_branch_id && i_regWrite_ex && match_ex;
    assign hz_bl = i_branch_id && i_memRead_ex_m && match_ex_m;
    assign hz    = hz_lu | hz_ba | hz_bl;

    always_comb begin
        state_next       = state;
        drain_cnt_next   = drain_cnt;
        program_end_next = program_end;
        stall_inc        = 1'b0;
        o_pc_write       = 1'b1;
        o_if_id_write    = 1'b1;
        o_id_ex_flush    = 1'b0;
        o_pipe_en        = 1'b1;

        case (state)
            ST_RUN, ST_STEP: begin
                // STEP is a single RUN cycle that falls back to HALTED unless
                // a HALT instruction sends it to DRAIN instead.
                if (state == ST_STEP)
                    state_next = ST_HALTED;
                if (i_halt_id) begin
                    o_pc_write       = 1'b0;
                    o_if_id_write    = 1'b0;
                    o_id_ex_flush    = 1'b1;
                    program_end_next = 1'b1;
                    drain_cnt_next   = DRAIN_INIT;
                    state_next       = ST_DRAIN;
                end else if (i_dbg_halt_req && (state == ST_RUN)) begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_flush  = 1'b1;
                    drain_cnt_next = DRAIN_INIT;
                    state_next     = ST_DRAIN;
                end else if (hz) begin
                    o_pc_write    = 1'b0;
                    o_if_id_write = 1'b0;
                    o_id_ex_flush = 1'b1;
                    stall_inc     = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Front end frozen; back end keeps advancing so in-flight
                // instructions retire.
                o_pc_write    = 1'b0;
                o_if_id_write = 1'b0;
                o_id_ex_flush = 1'b1;
                if (drain_cnt == '0)
                    state_next = ST_HALTED;
                else
                    drain_cnt_next = drain_cnt - CW'(1);
            end
            ST_HALTED: begin
                o_pc_write    = 1'b0;
                o_if_id_write = 1'b0;
                o_pipe_en     = 1'b0;
                if (i_dbg_step)
                    state_next = ST_STEP;
                else if (i_dbg_run && !program_end)
                    state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            program_end <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_cnt_next;
            program_end <= program_end_next;
            if (stall_inc)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign o_halted      = (state == ST_HALTED);
    assign o_program_end = program_end;
    assign o_stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    localparam int NB_ADDR = 5;
    localparam int NB_CNT  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NB_ADDR-1:0] rs_id, rt_id, rd_ex, rd_ex_m;
    logic               use_rs_id, use_rt_id, branch_id, halt_id;
    logic               regwrite_ex, memread_ex, memread_ex_m;
    logic               dbg_halt_req, dbg_step, dbg_run;
    logic               pc_write, if_id_write, id_ex_flush, pipe_en;
    logic               halted, program_end;
    logic [NB_CNT-1:0]  stall_count;

    int n_pass = 0;
    int n_total = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .NB_ADDR(NB_ADDR),
        .NB_CNT(NB_CNT),
        .DRAIN_CYCLES(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rs_id(rs_id),
        .i_rt_id(rt_id),
        .i_use_rs_id(use_rs_id),
        .i_use_rt_id(use_rt_id),
        .i_branch_id(branch_id),
        .i_halt_id(halt_id),
        .i_rd_ex(rd_ex),
        .i_regWrite_ex(regwrite_ex),
        .i_memRead_ex(memread_ex),
        .i_rd_ex_m(rd_ex_m),
        .i_memRead_ex_m(memread_ex_m),
        .i_dbg_halt_req(dbg_halt_req),
        .i_dbg_step(dbg_step),
        .i_dbg_run(dbg_run),
        .o_pc_write(pc_write),
        .o_if_id_write(if_id_write),
        .o_id_ex_flush(id_ex_flush),
        .o_pipe_en(pipe_en),
        .o_halted(halted),
        .o_program_end(program_end),
        .o_stall_count(stall_count)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       branch;
        logic [4:0] rd_ex;
        logic       regwr;
        logic       memrd;
        logic [4:0] rd_exm;
        logic       memrd_m;
        logic [3:0] exp_en;   // {pc_write, if_id_write, id_ex_flush, pipe_en}
        logic       stall;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_out(input string name, input logic [3:0] exp);
        chk(name, {12'd0, pc_write, if_id_write, id_ex_flush, pipe_en}, {12'd0, exp});
    endtask

    task automatic clear_in();
        rs_id = '0; rt_id = '0; rd_ex = '0; rd_ex_m = '0;
        use_rs_id = 0; use_rt_id = 0; branch_id = 0; halt_id = 0;
        regwrite_ex = 0; memread_ex = 0; memread_ex_m = 0;
        dbg_halt_req = 0; dbg_step = 0; dbg_run = 0;
    endtask

    task automatic set_lu();
        memread_ex = 1; regwrite_ex = 1; rd_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        clear_in();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk_out("reset_enables", 4'b1101);
        chk("reset_halted", 16'(halted), 16'd0);
        chk("reset_prog_end", 16'(program_end), 16'd0);
        chk("reset_count", 16'(stall_count), 16'd0);

        // rs rt urs urt br  rd_ex rw mr  rd_exm mrm  exp_en  stall
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1101, 1'b0};
        vecs[1]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0, 4'b0011, 1'b1};
        vecs[2]  = '{5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0011, 1'b1};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 4'b1101, 1'b0};
        vecs[4]  = '{5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b1101, 1'b0};
        vecs[5]  = '{5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 4'b0011, 1'b1};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 4'b1101, 1'b0};
        vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0011, 1'b1};
        vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 4'b1101, 1'b0};
        vecs[9]  = '{5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 4'b1101, 1'b0};
        vecs[10] = '{5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b1101, 1'b0};
        vecs[11] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 4'b1101, 1'b0};

        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rs_id = vecs[i].rs; rt_id = vecs[i].rt;
            use_rs_id = vecs[i].use_rs; use_rt_id = vecs[i].use_rt;
            branch_id = vecs[i].branch; rd_ex = vecs[i].rd_ex;
            regwrite_ex = vecs[i].regwr; memread_ex = vecs[i].memrd;
            rd_ex_m = vecs[i].rd_exm; memread_ex_m = vecs[i].memrd_m;
            #1;
            chk($sformatf("vec%0d_enables", i), {12'd0, pc_write, if_id_write, id_ex_flush, pipe_en},
                {12'd0, vecs[i].exp_en});
            tick();
            if (vecs[i].stall && exp_cnt < 3)
                exp_cnt++;
            chk($sformatf("vec%0d_count", i), 16'(stall_count), 16'(exp_cnt));
        end

        // HALT instruction: 4 drain cycles, then a halt that debug run cannot leave
        do_reset();
        halt_id = 1;
        #1;
        chk_out("halt_run_cycle", 4'b0011);
        tick();
        halt_id = 0;
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("halt_drain%0d", k), 4'b0011);
            chk($sformatf("halt_drain%0d_halted", k), 16'(halted), 16'd0);
            tick();
        end
        chk("halt_halted", 16'(halted), 16'd1);
        chk_out("halt_enables", 4'b0000);
        chk("halt_prog_end", 16'(program_end), 16'd1);
        @(negedge clk);
        dbg_run = 1;
        tick();
        dbg_run = 0;
        chk("halt_run_ignored", 16'(halted), 16'd1);
        chk("halt_count", 16'(stall_count), 16'd0);

        // Debug halt, single step (halt request held during the step), resume
        do_reset();
        dbg_halt_req = 1;
        #1;
        chk_out("dbg_run_cycle", 4'b0011);
        repeat (4) tick();
        chk("dbg_not_yet_halted", 16'(halted), 16'd0);
        tick();
        chk("dbg_halted", 16'(halted), 16'd1);
        chk("dbg_prog_end", 16'(program_end), 16'd0);
        @(negedge clk);
        dbg_step = 1;
        #1;
        chk_out("dbg_step_req_cycle", 4'b0000);
        tick();
        dbg_step = 0;
        chk_out("dbg_step_cycle", 4'b1101);
        chk("dbg_step_not_halted", 16'(halted), 16'd0);
        tick();
        chk("dbg_step_back_halted", 16'(halted), 16'd1);
        dbg_halt_req = 0;
        @(negedge clk);
        dbg_run = 1;
        tick();
        dbg_run = 0;
        chk("dbg_resumed", 16'(halted), 16'd0);
        chk_out("dbg_resumed_enables", 4'b1101);

        // Step and run together: step wins; hazard inside STEP is counted
        do_reset();
        dbg_halt_req = 1;
        tick();
        dbg_halt_req = 0;
        repeat (4) tick();
        chk("sr_halted", 16'(halted), 16'd1);
        @(negedge clk);
        dbg_step = 1;
        dbg_run = 1;
        tick();
        dbg_step = 0;
        dbg_run = 0;
        set_lu();
        #1;
        chk_out("sr_step_stall", 4'b0011);
        tick();
        clear_in();
        chk("sr_step_wins", 16'(halted), 16'd1);
        chk("sr_step_count", 16'(stall_count), 16'd1);

        // HALT seen during STEP goes to DRAIN
        @(negedge clk);
        dbg_step = 1;
        tick();
        dbg_step = 0;
        halt_id = 1;
        #1;
        chk_out("sh_step_halt", 4'b0011);
        tick();
        halt_id = 0;
        chk("sh_drain_not_halted", 16'(halted), 16'd0);
        chk_out("sh_drain_enables", 4'b0011);
        repeat (3) tick();
        chk("sh_drain_last", 16'(halted), 16'd0);
        tick();
        chk("sh_halted", 16'(halted), 16'd1);
        chk("sh_prog_end", 16'(program_end), 16'd1);

        // HALT beats LU (no count), then reset in the middle of DRAIN
        do_reset();
        set_lu();
        tick();
        clear_in();
        chk("hl_pre_count", 16'(stall_count), 16'd1);
        @(negedge clk);
        set_lu();
        halt_id = 1;
        #1;
        chk_out("hl_halt_cycle", 4'b0011);
        tick();
        clear_in();
        chk("hl_no_count", 16'(stall_count), 16'd1);
        chk("hl_prog_end", 16'(program_end), 16'd1);
        tick();
        @(negedge clk);
        rst = 1;
        tick();
        chk_out("rd_enables", 4'b1101);
        chk("rd_halted", 16'(halted), 16'd0);
        chk("rd_prog_end", 16'(program_end), 16'd0);
        chk("rd_count", 16'(stall_count), 16'd0);
        rst = 0;

        // Counter saturation with a 2-bit counter over 5 stalls
        do_reset();
        set_lu();
        exp_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (exp_cnt < 3)
                exp_cnt++;
            chk($sformatf("sat_count%0d", k), 16'(stall_count), 16'(exp_cnt));
        end
        clear_in();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequencing controller for the MIPS 5-stage pipeline.
- Detects load-use and branch-in-ID hazards that the ID/EX forwarding paths cannot cover. Generates PC / IF-ID write enables and the ID/EX bubble.
- Runs a run/drain/halt/step FSM driven by the HALT instruction and the debug unit.
- Sits beside the ID-stage forwarding logic and drives the enables of every pipeline register.

Parameters:
- NB_ADDR, 5, register address width
- NB_CNT, 16, width of the saturating stall-cycle counter
- DRAIN_CYCLES, 4, cycles the pipeline keeps advancing after a halt so in-flight instructions retire (minimum 1)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_rs_id  in  NB_ADDR  rs of the instruction in ID
- i_rt_id  in  NB_ADDR  rt of the instruction in ID
- i_use_rs_id  in  1  ID instruction reads rs
- i_use_rt_id  in  1  ID instruction reads rt
- i_branch_id  in  1  ID instruction is a branch/jr resolved in ID
- i_halt_id  in  1  ID instruction is HALT
- i_rd_ex  in  NB_ADDR  destination register in ID/EX
- i_regWrite_ex  in  1  ID/EX writes a register
- i_memRead_ex  in  1  ID/EX is a load
- i_rd_ex_m  in  NB_ADDR  destination register in EX/MEM
- i_memRead_ex_m  in  1  EX/MEM is a load
- i_dbg_halt_req  in  1  debug unit requests halt (level)
- i_dbg_step  in  1  single-cycle pulse: execute one cycle while halted
- i_dbg_run  in  1  single-cycle pulse: resume from debug halt
- o_pc_write  out  1  PC update enable
- o_if_id_write  out  1  IF/ID update enable
- o_id_ex_flush  out  1  load a bubble into ID/EX
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
- o_halted  out  1  FSM in HALTED
- o_program_end  out  1  halt was caused by a HALT instruction (sticky until reset)
- o_stall_count  out  NB_CNT  hazard-stall cycles since reset, saturating

Behaviour:
- Hazard terms are combinational. A match requires a nonzero destination register equal to rs (with i_use_rs_id) or rt (with i_use_rt_id).
  - LU: i_memRead_ex and a match on i_rd_ex.
  - BA: i_branch_id, i_regWrite_ex, and a match on i_rd_ex.
  - BL: i_branch_id, i_memRead_ex_m, and a match on i_rd_ex_m.
  - hz = LU | BA | BL. A branch on a load result therefore stalls 2 cycles (LU, then BL).
- FSM states: RUN, DRAIN, HALTED, STEP. Reset state: RUN, drain counter 0, o_program_end 0, o_stall_count 0.
- Outputs are combinational from state and hz; o_halted is a decode of the state register.
- Reset values of outputs: o_pc_write=1, o_if_id_write=1, o_id_ex_flush=0, o_pipe_en=1, o_halted=0, o_program_end=0, o_stall_count=0.
- RUN, with priority i_halt_id > i_dbg_halt_req > hz:
  - i_halt_id: pc_write=0, if_id_write=0, id_ex_flush=1; set o_program_end; counter=DRAIN_CYCLES-1; next DRAIN.
  - i_dbg_halt_req: same outputs and transition; o_program_end unchanged.
  - hz: pc_write=0, if_id_write=0, id_ex_flush=1, pipe_en=1; stay in RUN.
  - Otherwise all enables 1, flush 0.
- DRAIN: pc_write=0, if_id_write=0, id_ex_flush=1, pipe_en=1. Counter decrements each cycle; when the counter is 0, next state is HALTED.
- HALTED: pc_write=0, if_id_write=0, id_ex_flush=0, pipe_en=0, o_halted=1.
  - i_dbg_step: next STEP.
  - i_dbg_run with o_program_end=0: next RUN.
  - i_dbg_run with o_program_end=1: ignored; only reset leaves HALTED.
  - step and run in the same cycle: step wins.
- STEP: exactly one cycle of RUN behaviour, including hazard stalls and HALT detection, then HALTED.
  - A HALT in ID during STEP goes to DRAIN.
  - A debug halt request during STEP has no effect.
- o_stall_count increments in every cycle where hz causes a stall in RUN or STEP. It holds at all ones. DRAIN and HALTED cycles are not counted.
- Reset mid-DRAIN or mid-STEP: next cycle is RUN with reset values; the counter clears.

Test Plan:
1. Load-use: i_memRead_ex=1, i_rd_ex=8, i_rs_id=8, i_use_rs_id=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1, o_stall_count 0->1.
2. Branch on load: BL only, i_rd_ex_m=9, i_rt_id=9, i_use_rt_id=1, i_branch_id=1 -> one stall cycle. Destination register 0 in either hazard term -> no stall.
3. HALT instruction: i_halt_id=1 in RUN -> exactly 4 DRAIN cycles with pipe_en=1, then o_halted=1, pipe_en=0, o_program_end=1. i_dbg_run pulse -> remains HALTED.
4. Debug halt/step/run: i_dbg_halt_req -> HALTED after 4 cycles; i_dbg_step -> one cycle pc_write=1 then HALTED; i_dbg_run -> RUN.
5. Step and run in the same cycle -> STEP. i_halt_id and an LU hazard together in RUN -> DRAIN; o_stall_count not incremented.
6. With NB_CNT=2, 5 stall cycles -> o_stall_count=3. Reset asserted during DRAIN -> all outputs return to reset values next cycle.
